// File: rtl/pipe_skid_stage_if.sv
// Ready/valid handshake bundle for one skid-buffered pipeline stage.
// The slave modport is the stage; the master modport is the surrounding pipeline.
interface pipe_skid_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [31:0]      out_pc;

    modport slave (
        input  in_valid, in_data, in_pc, out_ready,
        output in_ready, out_valid, out_data, out_pc
    );

    modport master (
        output in_valid, in_data, in_pc, out_ready,
        input  in_ready, out_valid, out_data, out_pc
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage: registered in_ready, full throughput, flush discards held
// entries, with saturating stall and drop performance counters.
module pipe_skid_stage #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    pipe_skid_stage_if.slave  bus,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main_data;
    logic [31:0]      r_main_pc;
    logic [WIDTH-1:0] r_skid_data;
    logic [31:0]      r_skid_pc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_out_valid;
    logic             w_xfer_in;
    logic             w_xfer_out;
    logic             w_ld_main_in;
    logic             w_ld_skid;
    logic             w_mv_skid;
    logic [1:0]       w_drop_amt;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [1:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign w_out_valid = (r_state != EMPTY);
    assign w_xfer_in   = bus.in_valid && r_in_ready;
    assign w_xfer_out  = w_out_valid && bus.out_ready;
    // An entry delivered in the flush cycle is not a drop.
    assign w_drop_amt  = 2'(r_state) - {1'b0, w_xfer_out};

    always_comb begin
        w_state_nxt  = r_state;
        w_ld_main_in = 1'b0;
        w_ld_skid    = 1'b0;
        w_mv_skid    = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_xfer_in) begin
                    w_state_nxt  = ONE;
                    w_ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_xfer_in && w_xfer_out) begin
                    w_ld_main_in = 1'b1;
                end else if (w_xfer_in) begin
                    w_state_nxt = FULL;
                    w_ld_skid   = 1'b1;
                end else if (w_xfer_out) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_xfer_out) begin
                    w_state_nxt = ONE;
                    w_mv_skid   = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) begin
            w_state_nxt  = EMPTY;
            w_ld_main_in = 1'b0;
            w_ld_skid    = 1'b0;
            w_mv_skid    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main_data <= '0;
            r_main_pc   <= '0;
            r_skid_data <= '0;
            r_skid_pc   <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main_data <= bus.in_data;
                r_main_pc   <= bus.in_pc;
            end else if (w_mv_skid) begin
                r_main_data <= r_skid_data;
                r_main_pc   <= r_skid_pc;
            end
            if (w_ld_skid) begin
                r_skid_data <= bus.in_data;
                r_skid_pc   <= bus.in_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_out_valid && !bus.out_ready) begin
                r_stall_cnt <= sat_add(r_stall_cnt, 2'd1);
            end
            if (flush) begin
                r_drop_cnt <= sat_add(r_drop_cnt, w_drop_amt);
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main_data;
    assign bus.out_pc    = r_main_pc;
    assign occupancy     = 2'(r_state);
    assign stall_cnt     = r_stall_cnt;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 64: payload width in bits.
REQ-002 Parameter CNT_W, default 16: width of each performance counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  exception flush; discards all held entries.
REQ-006 in_valid  input  1  upstream offers an entry.
REQ-007 in_ready  output  1  stage can accept an entry.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 in_pc  input  32  PC of the offered instruction.
REQ-010 out_valid  output  1  stage presents an entry downstream.
REQ-011 out_ready  input  1  downstream accepts the presented entry.
REQ-012 out_data  output  WIDTH  presented payload.
REQ-013 out_pc  output  32  presented PC.
REQ-014 occupancy  output  2  number of held entries, 0..2.
REQ-015 stall_cnt  output  CNT_W  count of back-pressured cycles.
REQ-016 drop_cnt  output  CNT_W  count of entries discarded by flush.

Function
REQ-017 The block SHALL hold two entry registers: main (drives out_*) and skid; each entry holds {data, pc}.
REQ-018 The block SHALL implement states EMPTY (occupancy 0), ONE (1) and FULL (2).
REQ-019 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE and 0 in FULL; there is no combinational path from out_ready to in_ready.
REQ-020 Transfer-in SHALL be in_valid && in_ready; transfer-out SHALL be out_valid && out_ready.
REQ-021 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-022 EMPTY + transfer-in SHALL load main and move to ONE; latency in->out is 1 cycle.
REQ-023 ONE + transfer-in + transfer-out SHALL load main with the new entry and stay in ONE (full throughput).
REQ-024 ONE + transfer-in without transfer-out SHALL load skid and move to FULL; main is unchanged.
REQ-025 ONE + transfer-out without transfer-in SHALL move to EMPTY.
REQ-026 FULL + transfer-out SHALL copy skid into main and move to ONE; in_ready returns to 1 on the next cycle.
REQ-027 FULL without transfer-out SHALL hold main and skid unchanged.
REQ-028 Entries SHALL leave in arrival order; none is duplicated or lost except by flush or reset.
REQ-029 An invalid main or skid register SHALL keep its last value, except that reset and flush zero it.
REQ-030 flush SHALL, on the next edge, clear occupancy to 0, zero main and skid, and discard any same-cycle transfer-in; out_valid is 0 in the following cycle.
REQ-031 A transfer-out in the flush cycle SHALL still count as delivered to downstream.
REQ-032 stall_cnt SHALL increment by 1 in each cycle with out_valid && !out_ready, saturating at all-ones.
REQ-033 On a flush edge, drop_cnt SHALL increase by the pre-flush occupancy minus 1 if a transfer-out occurs in that cycle, saturating at all-ones.
REQ-034 flush SHALL NOT clear stall_cnt or drop_cnt.
REQ-035 occupancy SHALL be registered and SHALL equal 0/1/2 for EMPTY/ONE/FULL.

Reset
REQ-036 rst SHALL take priority over flush and all transfers.
REQ-037 After a reset edge, the outputs SHALL be: out_valid 0, in_ready 1, out_data 0, out_pc 0, occupancy 0, stall_cnt 0, drop_cnt 0, state EMPTY.
REQ-038 A reset asserted while in FULL SHALL discard both entries without incrementing drop_cnt.

Verification
REQ-039 Streaming test: hold out_ready=1 and present in_valid=1 with data 1..8 on consecutive cycles -> out_data shows 1..8 on consecutive cycles, each 1 cycle after input; in_ready stays 1; stall_cnt stays 0.
REQ-040 Back-pressure test: drive out_ready=0 and offer A, then B -> occupancy becomes 2 and in_ready 0; out_data=A is held; after 3 cycles stall_cnt=3; raising out_ready -> A then B delivered, in_ready=1 one cycle after A leaves.
REQ-041 Flush test: from FULL (A, B) with out_ready=0, pulse flush with in_valid=1 (C) -> next cycle occupancy 0, out_valid 0, out_data 0, out_pc 0, drop_cnt=2, and C is never delivered.
REQ-042 Flush with simultaneous delivery: in ONE (A) with out_ready=1, pulse flush -> A counted as delivered, drop_cnt unchanged.
REQ-043 Reset test: from FULL with stall_cnt=5, assert rst with flush=1 -> all outputs match REQ-037 and drop_cnt=0.
REQ-044 Saturation test: with CNT_W=4 and out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds there.
